// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: FSM states, opcodes,
// instruction classes and ALU operation codes.
package riscv_ctrl_pkg;

    localparam int unsigned STATE_W  = 3;
    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned FUNCT3_W = 3;
    localparam int unsigned ALUOP_W  = 2;
    localparam int unsigned CLASS_W  = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } ctrl_state_e;

    typedef enum logic [CLASS_W-1:0] {
        CLS_NONE  = 3'd0,
        CLS_RTYPE = 3'd1,
        CLS_ITYPE = 3'd2,
        CLS_LD    = 3'd3,
        CLS_SD    = 3'd4,
        CLS_BR    = 3'd5
    } instr_class_e;

    localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;

    localparam logic [FUNCT3_W-1:0] F3_BEQ = 3'b000;
    localparam logic [FUNCT3_W-1:0] F3_BNE = 3'b001;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    // beq takes on zero, bne on non-zero; funct3[0] selects the sense.
    function automatic logic branch_taken(input logic zero, input logic [FUNCT3_W-1:0] funct3);
        return zero ^ funct3[0];
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control bus between the multicycle control unit (master) and its datapath (slave).
interface multicycle_control_unit_if;
    import riscv_ctrl_pkg::*;

    logic [OPCODE_W-1:0] opcode;
    logic [FUNCT3_W-1:0] funct3;
    logic                zero;
    logic                mem_ready;

    logic                mem_req;
    logic                mem_we;
    logic                ir_write;
    logic                pc_write;
    logic                pc_src;
    logic                reg_write;
    logic                mem_to_reg;
    logic                alu_src;
    logic [ALUOP_W-1:0]  alu_op;
    logic                instr_done;
    logic                trap;
    logic [STATE_W-1:0]  state;

    modport master (
        input  opcode, funct3, zero, mem_ready,
        output mem_req, mem_we, ir_write, pc_write, pc_src, reg_write,
               mem_to_reg, alu_src, alu_op, instr_done, trap, state
    );

    modport slave (
        output opcode, funct3, zero, mem_ready,
        input  mem_req, mem_we, ir_write, pc_write, pc_src, reg_write,
               mem_to_reg, alu_src, alu_op, instr_done, trap, state
    );

endinterface

// File: rtl/instr_class_decoder.sv
// Maps opcode/funct3 to an instruction class; anything unsupported decodes as illegal.
module instr_class_decoder
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned EN_ITYPE = 1,
    parameter int unsigned EN_BNE   = 1
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic [FUNCT3_W-1:0] funct3_i,
    output instr_class_e        class_o,
    output logic                illegal_o
);

    always_comb begin
        class_o   = CLS_NONE;
        illegal_o = 1'b0;
        case (opcode_i)
            OP_RTYPE: class_o = CLS_RTYPE;
            OP_ITYPE: begin
                if (EN_ITYPE != 0) class_o = CLS_ITYPE;
            end
            OP_LOAD:  class_o = CLS_LD;
            OP_STORE: class_o = CLS_SD;
            OP_BRANCH: begin
                if (funct3_i == F3_BEQ || (EN_BNE != 0 && funct3_i == F3_BNE)) class_o = CLS_BR;
            end
            default:  class_o = CLS_NONE;
        endcase
        illegal_o = (class_o == CLS_NONE);
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-V control FSM: FETCH/DECODE/EXEC/MEM/WB with memory-wait
// timeout and an absorbing TRAP state.
module multicycle_control_unit
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned EN_ITYPE    = 1,
    parameter int unsigned EN_BNE      = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    multicycle_control_unit_if.master  bus
);

    // Counter only needs to reach MEM_TIMEOUT-1: the cycle that would reach the limit traps instead.
    localparam int unsigned CNT_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam int unsigned TMO_LAST = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;

    ctrl_state_e        state_q, state_d;
    instr_class_e       class_q, class_d;
    logic [CNT_W-1:0]   wait_q, wait_d;

    instr_class_e       dec_class;
    logic               dec_illegal;
    logic               timeout_hit_c;

    logic               mem_req_c;
    logic               mem_we_c;
    logic               ir_write_c;
    logic               pc_write_c;
    logic               pc_src_c;
    logic               reg_write_c;
    logic               mem_to_reg_c;
    logic               alu_src_c;
    logic [ALUOP_W-1:0] alu_op_c;
    logic               instr_done_c;
    logic               trap_c;

    instr_class_decoder #(
        .EN_ITYPE (EN_ITYPE),
        .EN_BNE   (EN_BNE)
    ) u_decoder (
        .opcode_i  (bus.opcode),
        .funct3_i  (bus.funct3),
        .class_o   (dec_class),
        .illegal_o (dec_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
            class_q <= CLS_NONE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            wait_q  <= wait_d;
        end
    end

    // Next state and control outputs; outputs depend on mem_ready in FETCH/MEM.
    always_comb begin
        state_d       = state_q;
        class_d       = class_q;
        wait_d        = wait_q;
        mem_req_c     = 1'b0;
        mem_we_c      = 1'b0;
        ir_write_c    = 1'b0;
        pc_write_c    = 1'b0;
        pc_src_c      = 1'b0;
        reg_write_c   = 1'b0;
        mem_to_reg_c  = 1'b0;
        alu_src_c     = 1'b0;
        alu_op_c      = ALUOP_ADD;
        instr_done_c  = 1'b0;
        trap_c        = 1'b0;
        timeout_hit_c = (MEM_TIMEOUT != 0) && (wait_q == CNT_W'(TMO_LAST));

        case (state_q)
            ST_FETCH: begin
                mem_req_c = 1'b1;
                if (bus.mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = ST_DECODE;
                end else if (timeout_hit_c) begin
                    state_d = ST_TRAP;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            ST_DECODE: begin
                class_d = dec_class;
                state_d = dec_illegal ? ST_TRAP : ST_EXEC;
            end
            ST_EXEC: begin
                case (class_q)
                    CLS_RTYPE: begin
                        alu_op_c = ALUOP_FUNCT;
                        state_d  = ST_WB;
                    end
                    CLS_ITYPE: begin
                        alu_src_c = 1'b1;
                        alu_op_c  = ALUOP_FUNCT;
                        state_d   = ST_WB;
                    end
                    CLS_LD, CLS_SD: begin
                        alu_src_c = 1'b1;
                        alu_op_c  = ALUOP_ADD;
                        state_d   = ST_MEM;
                    end
                    CLS_BR: begin
                        alu_op_c     = ALUOP_SUB;
                        pc_write_c   = branch_taken(bus.zero, bus.funct3);
                        pc_src_c     = branch_taken(bus.zero, bus.funct3);
                        instr_done_c = 1'b1;
                        state_d      = ST_FETCH;
                    end
                    default: state_d = ST_TRAP;
                endcase
            end
            ST_MEM: begin
                mem_req_c = 1'b1;
                mem_we_c  = (class_q == CLS_SD);
                if (bus.mem_ready) begin
                    if (class_q == CLS_SD) begin
                        instr_done_c = 1'b1;
                        state_d      = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (timeout_hit_c) begin
                    state_d = ST_TRAP;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            ST_WB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = (class_q == CLS_LD);
                instr_done_c = 1'b1;
                state_d      = ST_FETCH;
            end
            ST_TRAP: begin
                trap_c = 1'b1;
            end
            default: state_d = ST_TRAP;
        endcase

        // Every state change starts a fresh wait window.
        if (state_d != state_q) wait_d = '0;

        // Outputs are silenced while reset is held, even though the state already reads FETCH.
        if (rst) begin
            mem_req_c    = 1'b0;
            mem_we_c     = 1'b0;
            ir_write_c   = 1'b0;
            pc_write_c   = 1'b0;
            pc_src_c     = 1'b0;
            reg_write_c  = 1'b0;
            mem_to_reg_c = 1'b0;
            alu_src_c    = 1'b0;
            alu_op_c     = ALUOP_ADD;
            instr_done_c = 1'b0;
            trap_c       = 1'b0;
        end
    end

    assign bus.mem_req    = mem_req_c;
    assign bus.mem_we     = mem_we_c;
    assign bus.ir_write   = ir_write_c;
    assign bus.pc_write   = pc_write_c;
    assign bus.pc_src     = pc_src_c;
    assign bus.reg_write  = reg_write_c;
    assign bus.mem_to_reg = mem_to_reg_c;
    assign bus.alu_src    = alu_src_c;
    assign bus.alu_op     = alu_op_c;
    assign bus.instr_done = instr_done_c;
    assign bus.trap       = trap_c;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-instruction expected traces built from the
// instruction-class rules, two parameterisations driven in lockstep.
module tb_multicycle_control_unit;

    localparam int S_FETCH = 0, S_DECODE = 1, S_EXEC = 2, S_MEM = 3, S_WB = 4, S_TRAP = 5;
    localparam int C_ILL = 0, C_R = 1, C_I = 2, C_LD = 3, C_SD = 4, C_BR = 5;

    localparam logic [6:0] OPC_R  = 7'b0110011;
    localparam logic [6:0] OPC_I  = 7'b0010011;
    localparam logic [6:0] OPC_LD = 7'b0000011;
    localparam logic [6:0] OPC_SD = 7'b0100011;
    localparam logic [6:0] OPC_BR = 7'b1100011;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;
    int         checks;
    int         failures;
    logic [6:0] rand_ops [5];

    always #5 clk = ~clk;

    multicycle_control_unit_if bus_a ();
    multicycle_control_unit_if bus_b ();

    assign bus_a.opcode    = opcode;
    assign bus_a.funct3    = funct3;
    assign bus_a.zero      = zero;
    assign bus_a.mem_ready = mem_ready;
    assign bus_b.opcode    = opcode;
    assign bus_b.funct3    = funct3;
    assign bus_b.zero      = zero;
    assign bus_b.mem_ready = mem_ready;

    multicycle_control_unit #(.MEM_TIMEOUT(15), .EN_ITYPE(1), .EN_BNE(1)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a)
    );

    multicycle_control_unit #(.MEM_TIMEOUT(0), .EN_ITYPE(0), .EN_BNE(0)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b)
    );

    // Packed as {state, mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, mem_to_reg, alu_src, alu_op, instr_done, trap}.
    function automatic logic [14:0] ev(input int st, input logic mreq, input logic mwe, input logic irw,
                                       input logic pcw, input logic pcs, input logic rw, input logic m2r,
                                       input logic asrc, input logic [1:0] aop, input logic done, input logic trp);
        return {3'(st), mreq, mwe, irw, pcw, pcs, rw, m2r, asrc, aop, done, trp};
    endfunction

    function automatic logic [14:0] obs_a();
        return {bus_a.state, bus_a.mem_req, bus_a.mem_we, bus_a.ir_write, bus_a.pc_write, bus_a.pc_src,
                bus_a.reg_write, bus_a.mem_to_reg, bus_a.alu_src, bus_a.alu_op, bus_a.instr_done, bus_a.trap};
    endfunction

    function automatic logic [14:0] obs_b();
        return {bus_b.state, bus_b.mem_req, bus_b.mem_we, bus_b.ir_write, bus_b.pc_write, bus_b.pc_src,
                bus_b.reg_write, bus_b.mem_to_reg, bus_b.alu_src, bus_b.alu_op, bus_b.instr_done, bus_b.trap};
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(1, 0));
    endfunction

    task automatic chk(input string tag, input logic [14:0] obs, input logic [14:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: drive mem_ready, check dut_a mid-cycle, advance to just after the next edge.
    task automatic step_check(input string tag, input logic rdy, input logic [14:0] expv);
        mem_ready = rdy;
        @(negedge clk);
        chk(tag, obs_a(), expv);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            opcode = 7'($urandom);
            @(negedge clk);
            chk("rst_outputs_a", obs_a(), 15'd0);
            chk("rst_outputs_b", obs_b(), 15'd0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    // Expected trace of one instruction on dut_a, starting at the first FETCH cycle.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z, input int fw, input int mw);
        int   cls;
        logic taken;
        logic sd;
        opcode = op;
        funct3 = f3;
        zero   = z;
        if (op == OPC_R) cls = C_R;
        else if (op == OPC_I) cls = C_I;
        else if (op == OPC_LD) cls = C_LD;
        else if (op == OPC_SD) cls = C_SD;
        else if (op == OPC_BR && (f3 == 3'b000 || f3 == 3'b001)) cls = C_BR;
        else cls = C_ILL;
        taken = z ^ f3[0];
        sd    = (cls == C_SD);

        for (int i = 0; i < fw; i++)
            step_check("fetch_wait", 1'b0, ev(S_FETCH, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
        step_check("fetch_ready", 1'b1, ev(S_FETCH, 1, 0, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0));
        step_check("decode", rbit(), ev(S_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));

        case (cls)
            C_R: begin
                step_check("exec_r", rbit(), ev(S_EXEC, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0));
                step_check("wb_r", rbit(), ev(S_WB, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 1, 0));
            end
            C_I: begin
                step_check("exec_i", rbit(), ev(S_EXEC, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 0));
                step_check("wb_i", rbit(), ev(S_WB, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 1, 0));
            end
            C_LD, C_SD: begin
                step_check("exec_mem", rbit(), ev(S_EXEC, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0));
                for (int i = 0; i < mw; i++)
                    step_check("mem_wait", 1'b0, ev(S_MEM, 1, sd, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
                step_check("mem_ready", 1'b1, ev(S_MEM, 1, sd, 0, 0, 0, 0, 0, 0, 2'b00, sd, 0));
                if (!sd)
                    step_check("wb_ld", rbit(), ev(S_WB, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 1, 0));
            end
            C_BR: begin
                step_check("exec_br", rbit(), ev(S_EXEC, 0, 0, 0, taken, taken, 0, 0, 0, 2'b01, 1, 0));
            end
            default: begin
                step_check("illegal_trap", rbit(), ev(S_TRAP, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1));
            end
        endcase
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        clk       = 1'b0;
        rst       = 1'b1;
        opcode    = '0;
        funct3    = '0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        checks    = 0;
        failures  = 0;
        rand_ops  = '{OPC_R, OPC_I, OPC_LD, OPC_SD, OPC_BR};

        @(posedge clk);
        #1;
        do_reset(3);

        // Basic R-type and load with delayed memory.
        run_instr(OPC_R, 3'b000, 1'b0, 0, 0);
        run_instr(OPC_LD, 3'b010, 1'b0, 0, 3);

        // I-type: legal on dut_a, illegal on dut_b.
        run_instr(OPC_I, 3'b000, 1'b0, 1, 0);
        @(negedge clk);
        chk("b_itype_trap", obs_b(), ev(S_TRAP, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1));
        @(posedge clk);
        #1;
        do_reset(1);

        // bne: taken on dut_a, illegal on dut_b.
        run_instr(OPC_BR, 3'b001, 1'b0, 0, 0);
        @(negedge clk);
        chk("b_bne_trap", obs_b(), ev(S_TRAP, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1));
        @(posedge clk);
        #1;
        do_reset(1);

        // beq not taken; still legal on dut_b, which is back in FETCH.
        run_instr(OPC_BR, 3'b000, 1'b0, 0, 0);
        mem_ready = 1'b0;
        @(negedge clk);
        chk("b_beq_fetch", obs_b(), ev(S_FETCH, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
        @(posedge clk);
        #1;
        do_reset(1);

        run_instr(OPC_BR, 3'b000, 1'b1, 2, 0);
        run_instr(OPC_BR, 3'b001, 1'b1, 0, 0);
        run_instr(OPC_SD, 3'b010, 1'b0, 2, 1);

        // mem_ready arriving on the last allowed wait cycle wins over the timeout.
        run_instr(OPC_R, 3'b000, 1'b0, 14, 0);
        run_instr(OPC_LD, 3'b010, 1'b0, 0, 14);
        run_instr(OPC_SD, 3'b010, 1'b0, 14, 14);

        for (int n = 0; n < 40; n++) begin
            logic [6:0] op;
            logic [2:0] f3;
            op = rand_ops[$urandom_range(4, 0)];
            f3 = (op == OPC_BR) ? 3'($urandom_range(1, 0)) : 3'($urandom);
            run_instr(op, f3, rbit(), int'($urandom_range(6, 0)), int'($urandom_range(6, 0)));
        end

        // Illegal opcode and unsupported branch funct3 both trap and stay trapped.
        run_instr(7'b1111111, 3'b000, 1'b0, 0, 0);
        for (int i = 0; i < 3; i++)
            step_check("trap_hold", 1'b1, ev(S_TRAP, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1));
        do_reset(1);
        run_instr(OPC_BR, 3'b100, 1'b1, 0, 0);
        do_reset(1);

        // Fetch timeout on dut_a; dut_b has timeout disabled and keeps waiting.
        opcode = OPC_R;
        for (int i = 0; i < 15; i++)
            step_check("tmo_wait", 1'b0, ev(S_FETCH, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
        mem_ready = 1'b0;
        @(negedge clk);
        chk("tmo_trap_a", obs_a(), ev(S_TRAP, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1));
        chk("tmo_disabled_b", obs_b(), ev(S_FETCH, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            step_check("tmo_trap_sticky", rbit(), ev(S_TRAP, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1));
        do_reset(2);

        // Reset in the middle of a load's memory access.
        opcode = OPC_LD;
        funct3 = 3'b010;
        step_check("mid_fetch", 1'b1, ev(S_FETCH, 1, 0, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0));
        step_check("mid_decode", 1'b0, ev(S_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
        step_check("mid_exec", 1'b0, ev(S_EXEC, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0));
        step_check("mid_mem", 1'b0, ev(S_MEM, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
        mem_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_mem", obs_a(), 15'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_instr(OPC_R, 3'b000, 1'b0, 0, 0);
        run_instr(OPC_SD, 3'b010, 1'b0, 1, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
